// File: rtl/dma_io_peripheral.sv
// Device-side DMA peripheral: DREQ/DACK handshake with IOR_N/IOW_N strobes and a
// DEPTH-entry byte FIFO bridging the DMA bus to a host-side stream interface.
module dma_io_peripheral #(
    parameter int unsigned DEPTH       = 8,
    parameter bit          SINGLE_MODE = 1'b0
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   ENABLE,
    input  logic                   DIR,
    input  logic                   hWrValid,
    input  logic [7:0]             hWrData,
    output logic                   hWrReady,
    output logic                   hRdValid,
    output logic [7:0]             hRdData,
    input  logic                   hRdReady,
    output logic                   DREQ,
    input  logic                   DACK,
    input  logic                   IOR_N,
    input  logic                   IOW_N,
    input  logic                   EOP_N,
    input  logic [7:0]             DB_IN,
    output logic [7:0]             DB_OUT,
    output logic                   DB_OE,
    output logic                   DONE,
    output logic                   OVERRUN,
    output logic                   UNDERRUN,
    output logic [$clog2(DEPTH):0] COUNT
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL    = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_ACK, S_XFER, S_DONE} state_t;

    state_t        state, nxt;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count, count_next;
    logic [7:0]    wr_byte;
    logic          dir_q, dir_next, enable_q;
    logic          strobe, strobe_q, rise, commit;
    logic          eop_seen, eop_now, in_bus, req_cond;
    logic          full, empty;
    logic          host_push, host_pop, dma_push, dma_pop, push, pop;

    assign full      = (count == FULL);
    assign empty     = (count == '0);
    assign dir_next  = (ENABLE && !enable_q) ? DIR : dir_q;
    assign strobe    = dir_q ? IOW_N : IOR_N;
    assign rise      = !strobe_q && strobe;
    assign in_bus    = (state == S_ACK) || (state == S_XFER);
    assign eop_now   = in_bus && DACK && !EOP_N;
    assign req_cond  = ENABLE && (state != S_DONE) && (dir_next ? !full : !empty);
    assign commit    = (state == S_XFER) && rise;
    assign dma_pop   = commit && !dir_q && !empty;
    assign dma_push  = commit && dir_q && !full;
    assign host_push = hWrValid && hWrReady;
    assign host_pop  = hRdValid && hRdReady;
    assign push      = host_push || dma_push;
    assign pop       = host_pop || dma_pop;

    assign COUNT   = count;
    assign hRdData = hRdValid ? mem[rd_ptr] : '0;
    assign DB_OUT  = (DB_OE && !empty) ? mem[rd_ptr] : '0;

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + CNT_ONE;
        end else if (pop && !push) begin
            count_next = count - CNT_ONE;
        end
    end

    // Host-port readiness is registered from next-cycle occupancy and direction,
    // so both ports read 0 straight out of reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            hWrReady <= 1'b0;
            hRdValid <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            count    <= count_next;
            hWrReady <= !dir_next && (count_next != FULL);
            hRdValid <= dir_next && (count_next != '0);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET && push) begin
            mem[wr_ptr] <= host_push ? hWrData : wr_byte;
        end
    end

    always_comb begin
        nxt = state;
        unique case (state)
            S_IDLE: if (req_cond) nxt = S_REQ;
            S_REQ: begin
                if (DACK)           nxt = S_ACK;
                else if (!req_cond) nxt = S_IDLE;
            end
            S_ACK: begin
                if (!DACK)        nxt = S_REQ;
                else if (!strobe) nxt = S_XFER;
            end
            S_XFER: begin
                // A strobe rise wins over a simultaneous DACK drop.
                if (commit) begin
                    if (eop_seen || eop_now)          nxt = S_DONE;
                    else if (SINGLE_MODE || !req_cond) nxt = S_IDLE;
                    else                               nxt = S_REQ;
                end else if (!DACK) begin
                    nxt = S_IDLE;
                end
            end
            S_DONE: if (!ENABLE) nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= S_IDLE;
            DREQ     <= 1'b0;
            DB_OE    <= 1'b0;
            DONE     <= 1'b0;
            OVERRUN  <= 1'b0;
            UNDERRUN <= 1'b0;
            dir_q    <= 1'b0;
            enable_q <= 1'b0;
            strobe_q <= 1'b1;
            eop_seen <= 1'b0;
            wr_byte  <= '0;
        end else begin
            state    <= nxt;
            enable_q <= ENABLE;
            dir_q    <= dir_next;
            strobe_q <= strobe;
            DREQ     <= (nxt == S_REQ) || (nxt == S_ACK) || (nxt == S_XFER);
            DONE     <= (nxt == S_DONE);
            DB_OE    <= (nxt == S_XFER) && !dir_q;
            if (in_bus && dir_q && !IOW_N) wr_byte <= DB_IN;
            if ((nxt == S_IDLE) || (nxt == S_DONE)) eop_seen <= 1'b0;
            else if (eop_now)                      eop_seen <= 1'b1;
            if (!ENABLE) begin
                OVERRUN  <= 1'b0;
                UNDERRUN <= 1'b0;
            end else begin
                if (commit && dir_q && full)                   OVERRUN  <= 1'b1;
                if ((state == S_XFER) && !dir_q && empty)      UNDERRUN <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_dma_io_peripheral.sv
// Bench for dma_io_peripheral: vector table for the host fill path, queue-based
// FIFO model for randomized DMA/host traffic, and sequences for bus corner cases.
module tb_dma_io_peripheral;
    localparam int unsigned DEPTH = 8;

    logic       CLK = 1'b0;
    logic       RESET, ENABLE, DIR, hWrValid, hRdReady, DACK, IOR_N, IOW_N, EOP_N;
    logic [7:0] hWrData, DB_IN;

    logic       hWrReady, hRdValid, DREQ, DB_OE, DONE, OVERRUN, UNDERRUN;
    logic [7:0] hRdData, DB_OUT;
    logic [3:0] COUNT;

    logic       s_hWrReady, s_hRdValid, s_DREQ, s_DB_OE, s_DONE, s_OVERRUN, s_UNDERRUN;
    logic [7:0] s_hRdData, s_DB_OUT;
    logic [3:0] s_COUNT;

    dma_io_peripheral #(.DEPTH(DEPTH), .SINGLE_MODE(1'b0)) dut (
        .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .DIR(DIR),
        .hWrValid(hWrValid), .hWrData(hWrData), .hWrReady(hWrReady),
        .hRdValid(hRdValid), .hRdData(hRdData), .hRdReady(hRdReady),
        .DREQ(DREQ), .DACK(DACK), .IOR_N(IOR_N), .IOW_N(IOW_N), .EOP_N(EOP_N),
        .DB_IN(DB_IN), .DB_OUT(DB_OUT), .DB_OE(DB_OE), .DONE(DONE),
        .OVERRUN(OVERRUN), .UNDERRUN(UNDERRUN), .COUNT(COUNT)
    );

    dma_io_peripheral #(.DEPTH(DEPTH), .SINGLE_MODE(1'b1)) dut_single (
        .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .DIR(DIR),
        .hWrValid(hWrValid), .hWrData(hWrData), .hWrReady(s_hWrReady),
        .hRdValid(s_hRdValid), .hRdData(s_hRdData), .hRdReady(hRdReady),
        .DREQ(s_DREQ), .DACK(DACK), .IOR_N(IOR_N), .IOW_N(IOW_N), .EOP_N(EOP_N),
        .DB_IN(DB_IN), .DB_OUT(s_DB_OUT), .DB_OE(s_DB_OE), .DONE(s_DONE),
        .OVERRUN(s_OVERRUN), .UNDERRUN(s_UNDERRUN), .COUNT(s_COUNT)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    logic [7:0] model[$];

    typedef struct {
        logic       wv;
        logic [7:0] wd;
        logic       dir;
        logic [3:0] cnt;
        logic       dreq;
        logic       wrdy;
    } vec_t;
    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_bus();
        DACK = 1'b0; IOR_N = 1'b1; IOW_N = 1'b1; EOP_N = 1'b1;
        hWrValid = 1'b0; hRdReady = 1'b0; hWrData = 8'h00; DB_IN = 8'h00;
    endtask

    task automatic do_reset();
        RESET = 1'b1; ENABLE = 1'b0; DIR = 1'b0;
        idle_bus();
        step();
        step();
        RESET = 1'b0;
        model.delete();
    endtask

    task automatic enable_dir(input logic d);
        ENABLE = 1'b0;
        step();
        DIR = d;
        ENABLE = 1'b1;
        step();
    endtask

    task automatic wait_dreq();
        for (int k = 0; k < 12 && !DREQ; k++) step();
        chk("dreq_wait", DREQ, 1);
    endtask

    task automatic host_push(input logic [7:0] b);
        hWrValid = 1'b1;
        hWrData  = b;
        chk("wr_ready", hWrReady, 1);
        step();
        hWrValid = 1'b0;
        if (model.size() < DEPTH) model.push_back(b);
    endtask

    task automatic host_pop();
        chk("rd_valid", hRdValid, 1);
        chk("rd_data", hRdData, model[0]);
        hRdReady = 1'b1;
        step();
        hRdReady = 1'b0;
        void'(model.pop_front());
        chk("count_pop", COUNT, model.size());
    endtask

    task automatic dma_read(input bit eop, input bit hold);
        logic [7:0] exp;
        exp = (model.size() > 0) ? model[0] : 8'h00;
        wait_dreq();
        DACK = 1'b1;
        step();
        IOR_N = 1'b0;
        EOP_N = !eop;
        step();
        EOP_N = 1'b1;
        chk("db_oe", DB_OE, 1);
        chk("db_out", DB_OUT, exp);
        step();
        IOR_N = 1'b1;
        if (!hold) DACK = 1'b0;
        step();
        if (model.size() > 0) void'(model.pop_front());
        chk("count_rd", COUNT, model.size());
        chk("db_oe_off", DB_OE, 0);
    endtask

    task automatic dma_write(input logic [7:0] b, input bit hold);
        wait_dreq();
        DACK = 1'b1;
        step();
        IOW_N = 1'b0;
        DB_IN = b;
        step();
        chk("db_oe_wr", DB_OE, 0);
        step();
        IOW_N = 1'b1;
        DB_IN = ~b;
        if (!hold) DACK = 1'b0;
        step();
        if (model.size() < DEPTH) model.push_back(b);
        chk("count_wr", COUNT, model.size());
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0] = '{1'b1, 8'hA5, 1'b0, 4'd1, 1'b0, 1'b1};
        tbl[1] = '{1'b1, 8'h3C, 1'b0, 4'd2, 1'b1, 1'b1};
        tbl[2] = '{1'b0, 8'h00, 1'b0, 4'd2, 1'b1, 1'b1};
        tbl[3] = '{1'b1, 8'h01, 1'b1, 4'd3, 1'b1, 1'b1};
        tbl[4] = '{1'b1, 8'h02, 1'b1, 4'd4, 1'b1, 1'b1};
        tbl[5] = '{1'b1, 8'h03, 1'b0, 4'd5, 1'b1, 1'b1};
        tbl[6] = '{1'b1, 8'h04, 1'b0, 4'd6, 1'b1, 1'b1};
        tbl[7] = '{1'b1, 8'h05, 1'b0, 4'd7, 1'b1, 1'b1};
        tbl[8] = '{1'b1, 8'h06, 1'b0, 4'd8, 1'b1, 1'b0};
        tbl[9] = '{1'b1, 8'hFF, 1'b0, 4'd8, 1'b1, 1'b0};

        // Reset state
        do_reset();
        chk("rst_dreq", DREQ, 0);
        chk("rst_count", COUNT, 0);
        chk("rst_db_oe", DB_OE, 0);
        chk("rst_db_out", DB_OUT, 0);
        chk("rst_done", DONE, 0);
        chk("rst_overrun", OVERRUN, 0);
        chk("rst_underrun", UNDERRUN, 0);
        chk("rst_wr_ready", hWrReady, 0);
        chk("rst_rd_valid", hRdValid, 0);
        chk("rst_rd_data", hRdData, 0);

        // Host fill in device->memory mode, including DIR toggles and a push into a full FIFO
        enable_dir(1'b0);
        for (int i = 0; i < 10; i++) begin
            hWrValid = tbl[i].wv;
            hWrData  = tbl[i].wd;
            DIR      = tbl[i].dir;
            step();
            hWrValid = 1'b0;
            if (tbl[i].wv && model.size() < DEPTH) model.push_back(tbl[i].wd);
            chk($sformatf("tbl%0d_count", i), COUNT, tbl[i].cnt);
            chk($sformatf("tbl%0d_dreq", i), DREQ, tbl[i].dreq);
            chk($sformatf("tbl%0d_wrdy", i), hWrReady, tbl[i].wrdy);
            chk($sformatf("tbl%0d_rdvalid", i), hRdValid, 0);
        end
        DIR = 1'b0;
        while (model.size() > 0) dma_read(1'b0, 1'b0);
        step();
        chk("drain_dreq", DREQ, 0);
        chk("drain_count", COUNT, 0);

        // Underrun: DACK held past the last pop leads to a read from an empty FIFO
        host_push(8'h5A);
        dma_read(1'b0, 1'b1);
        dma_read(1'b0, 1'b0);
        chk("underrun_set", UNDERRUN, 1);
        chk("underrun_count", COUNT, 0);
        ENABLE = 1'b0;
        step();
        chk("underrun_clear", UNDERRUN, 0);
        ENABLE = 1'b1;
        step();

        // Randomized device->memory traffic
        for (int i = 0; i < 80; i++) begin
            if (model.size() < DEPTH && (model.size() == 0 || $urandom_range(0, 1) == 0))
                host_push(8'($urandom));
            else
                dma_read(1'b0, 1'b0);
        end
        while (model.size() > 0) dma_read(1'b0, 1'b0);

        // Memory->device: eight writes fill the FIFO, DREQ drops, host drains in order
        enable_dir(1'b1);
        chk("dir1_dreq", DREQ, 1);
        chk("dir1_wrdy", hWrReady, 0);
        for (int i = 0; i < 8; i++) dma_write(8'(8'h10 + i), 1'b0);
        step();
        chk("full_count", COUNT, 8);
        chk("full_dreq", DREQ, 0);
        for (int i = 0; i < 8; i++) host_pop();

        // Overrun: DACK held after the filling write lets one more strobe in
        for (int i = 0; i < 7; i++) dma_write(8'(8'h20 + i), 1'b0);
        dma_write(8'h27, 1'b1);
        dma_write(8'hFF, 1'b0);
        chk("overrun_set", OVERRUN, 1);
        chk("overrun_count", COUNT, 8);
        step();
        chk("overrun_dreq", DREQ, 0);
        for (int i = 0; i < 8; i++) host_pop();

        // Randomized memory->device traffic
        for (int i = 0; i < 80; i++) begin
            if (model.size() < DEPTH && (model.size() == 0 || $urandom_range(0, 1) == 0))
                dma_write(8'($urandom), 1'b0);
            else
                host_pop();
        end
        while (model.size() > 0) host_pop();

        // EOP during the second of four reads
        do_reset();
        enable_dir(1'b0);
        host_push(8'h11); host_push(8'h22); host_push(8'h33); host_push(8'h44);
        dma_read(1'b0, 1'b0);
        dma_read(1'b1, 1'b0);
        chk("eop_done", DONE, 1);
        chk("eop_dreq", DREQ, 0);
        chk("eop_count", COUNT, 2);
        step();
        chk("eop_done_sticky", DONE, 1);
        chk("eop_dreq_hold", DREQ, 0);
        ENABLE = 1'b0;
        step();
        chk("eop_done_clear", DONE, 0);
        ENABLE = 1'b1;
        step();
        chk("eop_dreq_back", DREQ, 1);
        while (model.size() > 0) dma_read(1'b0, 1'b0);

        // Single mode: DREQ low for exactly one cycle after each IOR_N rise
        do_reset();
        enable_dir(1'b0);
        host_push(8'hA1); host_push(8'hB2); host_push(8'hC3);
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < 12 && !s_DREQ; k++) step();
            chk("s_dreq_wait", s_DREQ, 1);
            DACK = 1'b1;
            step();
            IOR_N = 1'b0;
            step();
            chk("s_db_out", s_DB_OUT, model[0]);
            step();
            chk("s_dreq_pre", s_DREQ, 1);
            IOR_N = 1'b1;
            DACK = 1'b0;
            step();
            void'(model.pop_front());
            chk("s_dreq_drop", s_DREQ, 0);
            chk("s_count", s_COUNT, model.size());
            step();
            chk("s_dreq_after", s_DREQ, (model.size() > 0) ? 1 : 0);
        end

        // DACK drop mid-XFER aborts without a pop; RESET mid-XFER clears everything
        do_reset();
        enable_dir(1'b0);
        host_push(8'h77); host_push(8'h88);
        wait_dreq();
        DACK = 1'b1;
        step();
        IOR_N = 1'b0;
        step();
        chk("abort_db_oe_on", DB_OE, 1);
        DACK = 1'b0;
        step();
        chk("abort_count", COUNT, 2);
        chk("abort_db_oe", DB_OE, 0);
        IOR_N = 1'b1;
        step();
        chk("abort_count_rise", COUNT, 2);
        wait_dreq();
        DACK = 1'b1;
        step();
        IOR_N = 1'b0;
        step();
        chk("mid_db_out", DB_OUT, 8'h77);
        RESET = 1'b1;
        step();
        chk("mrst_dreq", DREQ, 0);
        chk("mrst_db_oe", DB_OE, 0);
        chk("mrst_db_out", DB_OUT, 0);
        chk("mrst_count", COUNT, 0);
        chk("mrst_wrdy", hWrReady, 0);
        chk("mrst_done", DONE, 0);
        RESET = 1'b0;
        idle_bus();
        model.delete();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
